// File: rtl/wide_add_sequencer.sv
// Multi-precision add/subtract sequencer: steps a shared 16-bit adder through
// WORDS slices, LSB first, chaining the carry through a register.
module wide_add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  op,
  input  logic [16*WORDS-1:0]   a,
  input  logic [16*WORDS-1:0]   b,
  output logic [15:0]           add_a,
  output logic [15:0]           add_b,
  output logic                  add_cin,
  input  logic [15:0]           add_sum,
  input  logic                  add_cout,
  output logic                  busy,
  output logic                  done,
  output logic [16*WORDS-1:0]   result,
  output logic                  carry_out,
  output logic                  overflow
);

  localparam int W  = 16 * WORDS;
  localparam int CW = $clog2(WORDS);
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic            op_q, op_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    result_q, result_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic [CW+3:0]   base;

  assign base = {cnt_q, 4'b0000};

  // Adder operands come only from registered state; quiet outside RUN.
  always_comb begin
    add_a   = 16'h0000;
    add_b   = 16'h0000;
    add_cin = 1'b0;
    if (state_q == RUN) begin
      add_a   = a_q[base +: 16];
      add_b   = b_q[base +: 16] ^ {16{op_q}};
      add_cin = carry_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          cnt_d   = '0;
          // Subtract's +1 enters as the slice-0 carry-in.
          carry_d = op;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        result_d[base +: 16] = add_sum;
        carry_d = add_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cout_d  = add_cout;
          ovf_d   = (add_a[15] == add_b[15]) && (add_sum[15] != add_a[15]);
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      op_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Testbench for wide_add_sequencer: a behavioural 16-bit adder closes the loop,
// and results are compared against whole-word arithmetic on the operands.
module tb_wide_add_sequencer;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [15:0]   add_a;
  logic [15:0]   add_b;
  logic          add_cin;
  logic [15:0]   add_sum;
  logic          add_cout;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          carry_out;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // The shared 16-bit adder the sequencer drives.
  assign {add_cout, add_sum} = 17'(add_a) + 17'(add_b) + 17'(add_cin);

  wide_add_sequencer #(.WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .busy(busy), .done(done), .result(result),
    .carry_out(carry_out), .overflow(overflow)
  );

  // Whole-word reference: unsigned result/carry plus signed overflow via sign extension.
  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic sub, output logic [W-1:0] r,
                                output logic c, output logic v);
    logic signed [W:0] sx, sy, s;
    logic [W:0] u;
    sx = $signed({x[W-1], x});
    sy = $signed({y[W-1], y});
    if (!sub) begin
      u = {1'b0, x} + {1'b0, y};
      r = u[W-1:0];
      c = u[W];
      s = sx + sy;
    end else begin
      r = x - y;
      c = (x >= y);
      s = sx - sy;
    end
    v = (s[W] != s[W-1]);
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    w = {$urandom, $urandom};
    case ($urandom_range(0, 5))
      0: w = '0;
      1: w = '1;
      2: w = {1'b0, {(W-1){1'b1}}};
      3: w = {1'b1, {(W-1){1'b0}}};
      default: ;
    endcase
    return w;
  endfunction

  // Called at a negedge; start is sampled at the following posedge, then operands are scrambled.
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub);
    a = x;
    b = y;
    op = sub;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    op = ~sub;
  endtask

  // Returns the number of negedges after the start edge at which done was seen, or -1.
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) begin
        n = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    a = '1;
    b = '1;
    op = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, carry_out, overflow, add_cin} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b expected 00000", {busy, done, carry_out, overflow, add_cin});
    end
    checks++;
    if (result !== '0) begin
      errors++;
      $display("[TB] FAIL reset_result: got %h expected 0", result);
    end
    checks++;
    if ({add_a, add_b} !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_adder_inputs: got %h expected 0", {add_a, add_b});
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] da[6], db[6], dr[6];
    logic dop[6], dc[6], dv[6];
    int n;
    da  = '{64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h5,
            64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
    db  = '{64'h1, 64'h1, 64'h1, 64'h3, 64'h1, 64'h1};
    dop = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    dr  = '{64'h0000_0001_0000_0000, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2,
            64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF};
    dc  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    dv  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      start_op(da[i], db[i], dop[i]);
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL dir%0d_busy: got %b expected 1", i, busy);
      end
      wait_done(n);
      checks++;
      if (n != WORDS) begin
        errors++;
        $display("[TB] FAIL dir%0d_latency: got %0d expected %0d", i, n, WORDS);
      end
      checks++;
      if (result !== dr[i]) begin
        errors++;
        $display("[TB] FAIL dir%0d_result: got %h expected %h", i, result, dr[i]);
      end
      checks++;
      if ({carry_out, overflow} !== {dc[i], dv[i]}) begin
        errors++;
        $display("[TB] FAIL dir%0d_cv: got %b expected %b", i, {carry_out, overflow}, {dc[i], dv[i]});
      end
      @(negedge clk);
      checks++;
      if ({done, busy} !== 2'b00 || result !== dr[i]) begin
        errors++;
        $display("[TB] FAIL dir%0d_after: got done/busy %b result %h expected 00 %h",
                 i, {done, busy}, result, dr[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] x, y, er;
    logic s, ec, ev;
    int n;
    for (int i = 0; i < 24; i++) begin
      x = rand_word();
      y = rand_word();
      s = 1'($urandom_range(0, 1));
      model(x, y, s, er, ec, ev);
      start_op(x, y, s);
      wait_done(n);
      checks++;
      if (n != WORDS || result !== er || {carry_out, overflow} !== {ec, ev}) begin
        errors++;
        $display("[TB] FAIL rand%0d: got lat %0d res %h cv %b expected lat %0d res %h cv %b",
                 i, n, result, {carry_out, overflow}, WORDS, er, {ec, ev});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] x1, y1, r1, x3, y3, r3, cap_r;
    logic c1, v1, c3, v3, cap_c, cap_v;
    int pulses, at_n, n;
    x1 = rand_word();
    y1 = rand_word();
    model(x1, y1, 1'b0, r1, c1, v1);
    pulses = 0;
    at_n = -1;
    cap_r = '0;
    cap_c = 1'b0;
    cap_v = 1'b0;
    start_op(x1, y1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      if (done === 1'b1) begin
        pulses++;
        at_n = k;
        cap_r = result;
        cap_c = carry_out;
        cap_v = overflow;
      end
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      op = 1'b1;
      start = 1'b1;
      @(negedge clk);
    end
    if (done === 1'b1) pulses++;
    checks++;
    if (pulses != 1 || at_n != WORDS) begin
      errors++;
      $display("[TB] FAIL busy_start_pulses: got %0d pulses at %0d expected 1 at %0d", pulses, at_n, WORDS);
    end
    checks++;
    if (cap_r !== r1 || {cap_c, cap_v} !== {c1, v1}) begin
      errors++;
      $display("[TB] FAIL busy_start_result: got %h cv %b expected %h cv %b", cap_r, {cap_c, cap_v}, r1, {c1, v1});
    end
    x3 = rand_word();
    y3 = rand_word();
    model(x3, y3, 1'b1, r3, c3, v3);
    start_op(x3, y3, 1'b1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL after_done_start_busy: got %b expected 1", busy);
    end
    wait_done(n);
    checks++;
    if (n != WORDS || result !== r3 || {carry_out, overflow} !== {c3, v3}) begin
      errors++;
      $display("[TB] FAIL after_done_start_result: got lat %0d res %h cv %b expected lat %0d res %h cv %b",
               n, result, {carry_out, overflow}, WORDS, r3, {c3, v3});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] x, y, er;
    logic ec, ev;
    int pulses, n;
    start_op(rand_word(), rand_word(), 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({busy, done, carry_out, overflow} !== 4'b0 || result !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mid_state: got flags %b result %h expected 0000 0",
               {busy, done, carry_out, overflow}, result);
    end
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("[TB] FAIL reset_mid_no_done: got %0d pulses expected 0", pulses);
    end
    x = rand_word();
    y = rand_word();
    model(x, y, 1'b1, er, ec, ev);
    start_op(x, y, 1'b1);
    wait_done(n);
    checks++;
    if (n != WORDS || result !== er || {carry_out, overflow} !== {ec, ev}) begin
      errors++;
      $display("[TB] FAIL reset_mid_recover: got lat %0d res %h cv %b expected lat %0d res %h cv %b",
               n, result, {carry_out, overflow}, WORDS, er, {ec, ev});
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so a stuck design still ends the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
